// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: records every retired writeback (rd + result) in a small
// circular FIFO, tagging each entry with a wrapping 8-bit sequence number.
// Entries drain over a valid/ready handshake. The core is never stalled, so
// entries that arrive while the buffer is full are dropped, and each drop is
// reported through a sticky overflow flag and a saturating counter.
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_valid,
  input  logic [4:0]          wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                clear,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W+12:0]  out_data,
  output logic [PTR_W:0]      count,
  output logic                overflow,
  output logic [7:0]          drop_cnt
);

  localparam int ENTRY_W = DATA_W + 13;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic mem_we;

  // Handshake decode; a pop in the same cycle frees the slot a push needs.
  always_comb begin
    full   = (count_q == DEPTH_C);
    pop    = (count_q != '0) && out_ready;
    push   = wb_valid && (!full || pop);
    drop   = wb_valid && full && !pop;
    mem_we = push && !clear;
  end

  // Next-state for pointers, occupancy, sequence tag and loss reporting.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      seq_d      = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        seq_d    = seq_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  // Control state register; reset empties the buffer without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; contents are don't-care after reset or clear, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= {seq_q, wb_rd, wb_data};
    end
  end

  // Output view of the head entry and status.
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule
